// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the pipelined MIPS core.
// Latches register-file operands and decoded controls for EX, applies the
// WB-stage bypass, precomputes EX forward selects and inserts one bubble
// per load-use hazard.
//
// Ports:
//   PCclk, rst           pipeline clock, async active-high reset
//   id_*                 ID-stage instruction, operands (Adat/Bdat), controls
//   flush                taken branch/jump: squash the ID instruction
//   mem_rd, mem_regwrite destination of the instruction in MEM
//   wb_rd/regwrite/dat   WB write port (same as regfile regW/RegWrite/Wdat)
//   stall                hold PC and IF/ID (combinational)
//   ex_*                 latched instruction for EX
//   ex_fwd_a/b           00 latched, 01 EX/MEM result, 10 MEM/WB data
//   bubble_cnt           saturating count of load-use bubbles
module id_ex_stage #(
  parameter int W_CNT = 16
) (
  input  logic             PCclk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      id_rs_dat,
  input  logic [31:0]      id_rt_dat,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_imm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic [3:0]       id_aluop,
  input  logic             flush,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic [31:0]      wb_dat,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic [3:0]       ex_aluop,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [W_CNT-1:0] bubble_cnt
);

  // Controls: cleared on every bubble.
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic [3:0] aluop;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } ctl_t;

  // Data: held through bubbles.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } dat_t;

  ctl_t             r_ctl;
  dat_t             r_dat;
  logic [W_CNT-1:0] r_cnt;

  ctl_t w_ctl;
  dat_t w_dat;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_stall;
  logic w_take;
  logic w_ex_wr;

  // Nearest producer first: EX now will be in MEM, MEM now in WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] s,
    input logic       ex_w,
    input logic [4:0] ex_d,
    input logic       mem_w,
    input logic [4:0] mem_d
  );
    if (s == 5'd0)
      return 2'b00;
    else if (ex_w && ex_d == s)
      return 2'b01;
    else if (mem_w && mem_d == s)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Covers a regfile write and read landing on the same edge.
  function automatic logic [31:0] opnd(
    input logic [4:0]  s,
    input logic [31:0] d,
    input logic        wb_w,
    input logic [4:0]  wb_d,
    input logic [31:0] wb_v
  );
    if (s == 5'd0)
      return 32'd0;
    else if (wb_w && wb_d == s)
      return wb_v;
    else
      return d;
  endfunction

  assign w_rs_hit = (r_dat.rd == id_rs);
  assign w_rt_hit = (r_dat.rd == id_rt);
  assign w_ex_wr  = r_ctl.valid & r_ctl.regwrite;

  assign w_stall = id_valid & r_ctl.valid & r_ctl.memread
                 & (r_dat.rd != 5'd0)
                 & (w_rs_hit | w_rt_hit) & ~flush;

  assign w_take = id_valid & ~flush & ~w_stall;

  always_comb begin
    w_ctl = '0;
    w_dat = r_dat;
    if (w_take) begin
      w_ctl.valid    = 1'b1;
      w_ctl.regwrite = id_regwrite;
      w_ctl.memread  = id_memread;
      w_ctl.memwrite = id_memwrite;
      w_ctl.alusrc   = id_alusrc;
      w_ctl.aluop    = id_aluop;
      w_ctl.fwd_a    = fwd_sel(id_rs, w_ex_wr, r_dat.rd,
                               mem_regwrite, mem_rd);
      w_ctl.fwd_b    = fwd_sel(id_rt, w_ex_wr, r_dat.rd,
                               mem_regwrite, mem_rd);
      w_dat.a   = opnd(id_rs, id_rs_dat, wb_regwrite, wb_rd, wb_dat);
      w_dat.b   = opnd(id_rt, id_rt_dat, wb_regwrite, wb_rd, wb_dat);
      w_dat.imm = id_imm;
      w_dat.rs  = id_rs;
      w_dat.rt  = id_rt;
      w_dat.rd  = id_rd;
    end
  end

  always_ff @(posedge PCclk or posedge rst) begin
    if (rst) begin
      r_ctl <= '0;
      r_dat <= '0;
      r_cnt <= '0;
    end else begin
      r_ctl <= w_ctl;
      r_dat <= w_dat;
      if (w_stall && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign ex_valid    = r_ctl.valid;
  assign ex_regwrite = r_ctl.regwrite;
  assign ex_memread  = r_ctl.memread;
  assign ex_memwrite = r_ctl.memwrite;
  assign ex_alusrc   = r_ctl.alusrc;
  assign ex_aluop    = r_ctl.aluop;
  assign ex_fwd_a    = r_ctl.fwd_a;
  assign ex_fwd_b    = r_ctl.fwd_b;
  assign ex_a        = r_dat.a;
  assign ex_b        = r_dat.b;
  assign ex_imm      = r_dat.imm;
  assign ex_rs       = r_dat.rs;
  assign ex_rt       = r_dat.rt;
  assign ex_rd       = r_dat.rd;
  assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random + directed scoreboard bench for id_ex_stage.
// Expected EX contents come from an instruction-level model of the stage.
module tb_id_ex_stage;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic PCclk = 0;
  logic rst = 1;
  logic id_valid = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic [31:0] id_rs_dat = 0, id_rt_dat = 0, id_imm = 0;
  logic id_regwrite = 0, id_memread = 0;
  logic id_memwrite = 0, id_alusrc = 0;
  logic [3:0] id_aluop = 0;
  logic flush = 0;
  logic [4:0] mem_rd = 0, wb_rd = 0;
  logic mem_regwrite = 0, wb_regwrite = 0;
  logic [31:0] wb_dat = 0;
  logic stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic ex_regwrite, ex_memread, ex_memwrite, ex_alusrc;
  logic [3:0] ex_aluop;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [CW-1:0] bubble_cnt;

  id_ex_stage #(.W_CNT(CW)) dut (
    .PCclk(PCclk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_dat(id_rs_dat), .id_rt_dat(id_rt_dat),
    .id_rd(id_rd), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .flush(flush),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_dat(wb_dat),
    .stall(stall), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .ex_fwd_a(ex_fwd_a),
    .ex_fwd_b(ex_fwd_b), .bubble_cnt(bubble_cnt)
  );

  always #5 PCclk = ~PCclk;

  typedef struct {
    logic v;
    logic [4:0] rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic rw, mr, mw, as;
    logic [3:0] op;
    logic fl;
    logic [4:0] mrd;
    logic mrw;
    logic [4:0] wrd;
    logic wrw;
    logic [31:0] wd;
  } stim_t;

  typedef struct {
    logic valid, rw, mr, mw, as;
    logic [3:0] op;
    logic [1:0] fa, fb;
    logic [31:0] a, b, imm;
    logic [4:0] rs, rt, rd;
  } ex_t;

  typedef struct {
    logic stall;
    ex_t ex;
    int cnt;
  } exp_t;

  exp_t q[$];
  ex_t m;
  int m_cnt;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stall"}, stall, 0);
    chk({tag, " ex_valid"}, ex_valid, 0);
    chk({tag, " ex_a"}, ex_a, 0);
    chk({tag, " ex_b"}, ex_b, 0);
    chk({tag, " ex_imm"}, ex_imm, 0);
    chk({tag, " regs"}, {ex_rs, ex_rt, ex_rd}, 0);
    chk({tag, " ctl"}, {ex_regwrite, ex_memread, ex_memwrite,
                        ex_alusrc, ex_aluop}, 0);
    chk({tag, " fwd"}, {ex_fwd_a, ex_fwd_b}, 0);
    chk({tag, " bubble_cnt"}, bubble_cnt, 0);
  endtask

  function automatic void model_reset();
    m = '{default: 0};
    m_cnt = 0;
  endfunction

  // Which stage will hold the nearest writer of s after this edge.
  function automatic logic [1:0] m_fwd(input logic [4:0] s,
                                       input stim_t t);
    if (s == 0) return 2'b00;
    if (m.valid && m.rw && m.rd == s) return 2'b01;
    if (t.mrw && t.mrd == s) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] s,
                                         input logic [31:0] d,
                                         input stim_t t);
    if (s == 0) return 0;
    if (t.wrw && t.wrd == s) return t.wd;
    return d;
  endfunction

  function automatic exp_t model_step(input stim_t t);
    exp_t e;
    logic hz;
    hz = t.v && m.valid && m.mr && m.rd != 0 &&
         (m.rd == t.rs || m.rd == t.rt);
    e.stall = hz && !t.fl;
    if (t.fl || e.stall || !t.v) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.as = 0;
      m.op = 0; m.fa = 0; m.fb = 0;
    end else begin
      m.fa = m_fwd(t.rs, t);
      m.fb = m_fwd(t.rt, t);
      m.valid = 1; m.rw = t.rw; m.mr = t.mr; m.mw = t.mw;
      m.as = t.as; m.op = t.op;
      m.a = m_opnd(t.rs, t.rsd, t);
      m.b = m_opnd(t.rt, t.rtd, t);
      m.imm = t.imm; m.rs = t.rs; m.rt = t.rt; m.rd = t.rd;
    end
    if (e.stall && m_cnt < CMAX) m_cnt++;
    e.ex = m;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic apply(input stim_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    id_rs_dat = t.rsd; id_rt_dat = t.rtd; id_imm = t.imm;
    id_regwrite = t.rw; id_memread = t.mr;
    id_memwrite = t.mw; id_alusrc = t.as; id_aluop = t.op;
    flush = t.fl; mem_rd = t.mrd; mem_regwrite = t.mrw;
    wb_rd = t.wrd; wb_regwrite = t.wrw; wb_dat = t.wd;
  endtask

  task automatic drive(input stim_t t);
    @(negedge PCclk);
    apply(t);
    q.push_back(model_step(t));
  endtask

  function automatic stim_t idle();
    stim_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic stim_t rnd();
    stim_t t;
    t.v = ($urandom_range(0, 7) != 0);
    t.rs = 5'($urandom_range(0, 7));
    t.rt = 5'($urandom_range(0, 7));
    t.rd = 5'($urandom_range(0, 7));
    t.rsd = $urandom;
    t.rtd = (t.rt == 0) ? 32'd0 : $urandom;
    t.imm = $urandom;
    t.mr = ($urandom_range(0, 2) == 0);
    t.rw = t.mr | 1'($urandom);
    t.mw = !t.mr && ($urandom_range(0, 3) == 0);
    t.as = 1'($urandom);
    t.op = 4'($urandom);
    t.fl = ($urandom_range(0, 7) == 0);
    t.mrd = 5'($urandom_range(0, 7));
    t.mrw = 1'($urandom);
    t.wrd = 5'($urandom_range(0, 7));
    t.wrw = 1'($urandom);
    t.wd = $urandom;
    return t;
  endfunction

  function automatic stim_t ld(input logic [4:0] rd);
    stim_t t;
    t = idle();
    t.v = 1; t.rs = 1; t.rt = 2; t.rd = rd;
    t.rsd = 32'h11; t.rtd = 32'h22;
    t.mr = 1; t.rw = 1; t.op = 4'h2; t.as = 1;
    return t;
  endfunction

  // Monitor: stall sampled mid-cycle, EX outputs just after the edge.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge PCclk);
      #3 s = stall;
      @(posedge PCclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", s, e.stall);
        chk("ex_valid", ex_valid, e.ex.valid);
        chk("ex_ctl", {ex_regwrite, ex_memread, ex_memwrite,
                       ex_alusrc, ex_aluop},
            {e.ex.rw, e.ex.mr, e.ex.mw, e.ex.as, e.ex.op});
        chk("ex_fwd_a", ex_fwd_a, e.ex.fa);
        chk("ex_fwd_b", ex_fwd_b, e.ex.fb);
        chk("ex_a", ex_a, e.ex.a);
        chk("ex_b", ex_b, e.ex.b);
        chk("ex_imm", ex_imm, e.ex.imm);
        chk("ex_regs", {ex_rs, ex_rt, ex_rd},
            {e.ex.rs, e.ex.rt, e.ex.rd});
        chk("bubble_cnt", bubble_cnt, e.cnt);
      end
    end
  end

  initial begin
    stim_t t;
    exp_t e;
    model_reset();
    #1 chk_zero("reset");
    #6 rst = 0;

    // Load-use on rs: one stall, then forward from MEM/WB.
    drive(ld(8));
    t = idle(); t.v = 1; t.rs = 8; t.rt = 3; t.rd = 4;
    t.rsd = 32'h5; t.rtd = 32'h6; t.rw = 1;
    drive(t);
    t.mrd = 8; t.mrw = 1;
    drive(t);

    // EX producer beats MEM producer.
    t = idle(); t.v = 1; t.rd = 5; t.rw = 1; t.rs = 1; t.rt = 2;
    drive(t);
    t = idle(); t.v = 1; t.rs = 6; t.rt = 5; t.rd = 7;
    t.rtd = 32'h77; t.mrd = 5; t.mrw = 1;
    drive(t);

    // WB bypass into latched rs operand.
    t = idle(); t.v = 1; t.rs = 3; t.rt = 4; t.rd = 9;
    t.rsd = 0; t.rtd = 32'h44;
    t.wrd = 3; t.wrw = 1; t.wd = 32'hDEADBEEF;
    drive(t);

    // Register $0: load into $0 never stalls or forwards.
    drive(ld(0));
    t = idle(); t.v = 1; t.rs = 0; t.rt = 0; t.rd = 2;
    t.rsd = 32'hCAFEF00D; t.mrd = 0; t.mrw = 1;
    t.wrd = 0; t.wrw = 1; t.wd = 32'h1234;
    drive(t);

    // Flush over stall: no stall, bubble, count unchanged.
    drive(ld(9));
    t = idle(); t.v = 1; t.rs = 9; t.rt = 1; t.rd = 3; t.fl = 1;
    drive(t);

    // Repeated hazards drive the counter to saturation.
    for (int i = 0; i < CMAX + 4; i++) begin
      drive(ld(10));
      t = idle(); t.v = 1; t.rs = 2; t.rt = 10; t.rd = 11;
      t.rw = 1;
      drive(t);
      drive(t);
    end

    for (int i = 0; i < 1500; i++) drive(rnd());

    // Reset asserted while a stall is pending.
    @(posedge PCclk);
    #2 rst = 1;
    #1 chk_zero("reset_mid_run");
    @(posedge PCclk);
    #2 rst = 0;
    model_reset();
    drive(ld(12));
    @(negedge PCclk);
    t = idle(); t.v = 1; t.rs = 12; t.rt = 1; t.rd = 13;
    apply(t);
    e = model_step(t);
    #2 chk("stall_before_reset", stall, e.stall);
    rst = 1;
    #1 chk_zero("reset_mid_stall");
    q.delete();
    model_reset();
    @(posedge PCclk);
    #1 chk("cnt_after_reset_edge", bubble_cnt, 0);
    chk("valid_after_reset_edge", ex_valid, 0);
    #1 rst = 0;

    for (int i = 0; i < 800; i++) drive(rnd());
    drive(idle());
    @(posedge PCclk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with hazard control for the pipelined MIPS core. Sits directly downstream of the register file. On each `PCclk` edge it latches the `Adat`/`Bdat` operands and decoded controls for the EX stage. It applies the WB-stage bypass, precomputes registered EX forwarding selects, and detects load-use hazards, inserting one bubble per hazard. Branch flush turns the captured instruction into a bubble.

## Interface
- `W_CNT`, default 16: width of the saturating bubble counter.
- `PCclk` in 1: pipeline clock, all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs`, `id_rt` in 5: source register numbers, also driving the register file `regA`/`regB`.
- `id_rs_dat`, `id_rt_dat` in 32: register file `Adat`/`Bdat`.
- `id_rd` in 5: destination register, already muxed rt/rd by decode.
- `id_imm` in 32: sign- or zero-extended immediate.
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_alusrc` in 1 each: decoded controls.
- `id_aluop` in 4: ALU operation.
- `flush` in 1: taken branch/jump resolved in EX; squash the ID instruction.
- `mem_rd` in 5, `mem_regwrite` in 1: destination of the instruction currently in MEM.
- `wb_rd` in 5, `wb_regwrite` in 1, `wb_dat` in 32: WB-stage write port, the same values driving register file `regW`/`RegWrite`/`Wdat`.
- `stall` out 1: hold PC and IF/ID (combinational).
- `ex_valid` out 1: EX holds a real instruction.
- `ex_a`, `ex_b`, `ex_imm` out 32: latched operands and immediate.
- `ex_rs`, `ex_rt`, `ex_rd` out 5: latched register numbers.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_alusrc` out 1 each; `ex_aluop` out 4: latched controls.
- `ex_fwd_a`, `ex_fwd_b` out 2: EX operand select. 00 = `ex_a`/`ex_b`; 01 = EX/MEM result; 10 = MEM/WB data.
- `bubble_cnt` out `W_CNT`: count of load-use bubbles, saturating.

## Operation
- **Load-use detection:**
  - `stall` = `id_valid` & `ex_valid` & `ex_memread` & (`ex_rd` != 0) & (`ex_rd` == `id_rs` | `ex_rd` == `id_rt`) & !`flush`.
- **Capture:** each edge, exactly one action, in this priority order:
  1. `rst`: all outputs clear.
  2. `flush`: bubble.
  3. `stall`: bubble; the ID instruction is not consumed.
  4. Otherwise: capture the ID inputs.
- **Bubble:** `ex_valid`, all `ex_*` controls and `ex_fwd_*` are 0; data fields hold their previous values.
- **Capture with `id_valid` = 0:** equivalent to a bubble.
- **Forward select per source s (`id_rs` → a, `id_rt` → b), computed at capture:**
  - s == 0: 00.
  - `ex_valid` & `ex_regwrite` & `ex_rd` == s: 01 (producer is one ahead; it will be in MEM next cycle).
  - `mem_regwrite` & `mem_rd` == s: 10 (it will be in WB next cycle).
  - Otherwise: 00.
  - The nearest producer wins.
- **WB bypass into latched data:** if `wb_regwrite` & `wb_rd` != 0 & `wb_rd` == s, the latched operand takes `wb_dat`; otherwise it takes `id_*_dat`.
  - This covers the same-cycle register-file write/read ordering.
  - The bypass applies even when `ex_fwd` != 00; EX ignores the latched value in that case.
- **Register $0:** never forwarded or bypassed. `ex_a` for rs = 0 is always 0.
- **Bubble counter:** `bubble_cnt` increments on each edge where `stall` is 1 and `flush` is 0. It saturates at all-ones.

## Timing
- **Reset values:** all `ex_*` outputs, `ex_valid`, `ex_fwd_a`/`ex_fwd_b` and `bubble_cnt` = 0. `stall` = 0 while `rst` is high, because `ex_valid` = 0.
- **Reset mid-stall:** clears immediately and asynchronously; no bubble is counted.
- **Latency:** 1 cycle, ID inputs to `ex_*` outputs.
- **Stall length:** exactly 1 cycle per load-use hazard. After the bubble, the load is in MEM and the same comparison yields fwd 10.
- **`stall` path:** combinational from registered `ex_*` and current `id_*`/`flush`. It has no dependency on `wb_*` or `mem_*`.
- **Flush and stall together:** `flush` wins. `stall` = 0, a bubble is inserted and the counter is not incremented.
- **Back-to-back loads:** each dependent pair stalls independently. Two consecutive stall cycles never occur for a single hazard.

## Test plan
- **Reset:** assert `rst` mid-run → all outputs 0 on the next sample, no clock needed; `bubble_cnt` = 0.
- **Load-use:** `ex_memread`=1, `ex_rd`=8, `id_rs`=8 → `stall`=1 for one edge, then bubble (`ex_valid`=0). Next edge: `ex_rs`=8, `ex_fwd_a`=10, `bubble_cnt`=1.
- **EX forward priority:** `ex_rd`=5 with `ex_regwrite`, `mem_rd`=5 with `mem_regwrite`, `id_rt`=5 → `ex_fwd_b`=01, no stall.
- **WB bypass:** `wb_rd`=3, `wb_dat`=32'hDEADBEEF, `id_rs`=3, `id_rs_dat`=0 → `ex_a`=32'hDEADBEEF, `ex_fwd_a`=00.
- **Register $0:** `id_rs`=0 with `ex_rd`=0, `ex_regwrite`=1, `ex_memread`=1 → `stall`=0, `ex_fwd_a`=00, `ex_a`=0.
- **Flush over stall, and saturation:** load-use hazard with `flush`=1 → `stall`=0, bubble inserted, `bubble_cnt` unchanged. Preload 16'hFFFF then force 3 hazards → stays 16'hFFFF.
